// File: rtl/server_rx_monitor_pkg.sv
// Shared constants, types and helpers for the server rx monitor.
// Error codes, ethertype, MAC head, FSM states, report bundle.
package server_rx_monitor_pkg;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_RUNT  = 3'd1;
  localparam logic [2:0] ERR_DEST  = 3'd2;
  localparam logic [2:0] ERR_ETYPE = 3'd3;
  localparam logic [2:0] ERR_LEN   = 3'd4;
  localparam logic [2:0] ERR_TUSER = 3'd5;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [31:0] MAC_HEAD = 32'h8DBC_5C4A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR1,
    S_PAYLOAD,
    S_DRAIN
  } rx_state_e;

  typedef struct packed {
    logic [47:0] src;
    logic [63:0] lat;
    logic [15:0] len;
    logic [2:0]  err;
  } rx_rpt_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [2:0] pick_err(
    input logic runt,
    input logic dest,
    input logic etype,
    input logic len,
    input logic tuser
  );
    if (runt)       return ERR_RUNT;
    else if (dest)  return ERR_DEST;
    else if (etype) return ERR_ETYPE;
    else if (len)   return ERR_LEN;
    else if (tuser) return ERR_TUSER;
    else            return ERR_OK;
  endfunction

endpackage

// File: rtl/server_rx_monitor_if.sv
// AXI-stream packet bus into the rx monitor.
// master drives tvalid/tdata/tlast/tkeep/tuser; slave drives tready.
interface server_rx_monitor_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tuser;
  logic        tready;

  modport master (
    output tvalid, tdata, tlast, tkeep, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tkeep, tuser,
    output tready
  );
endinterface

// File: rtl/rx_lat_stats.sv
// Packet statistics: good/bad counters, latency min/max/sum.
// Ports: i_clr clears (wins over i_upd); i_upd/i_good/i_lat per report.
module rx_lat_stats
  import server_rx_monitor_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_upd,
  input  logic        i_good,
  input  logic [63:0] i_lat,
  output logic [31:0] o_rx_pkt_cnt,
  output logic [31:0] o_err_cnt,
  output logic [63:0] o_lat_min,
  output logic [63:0] o_lat_max,
  output logic [63:0] o_lat_sum
);

  logic [64:0] sum_ext;

  assign sum_ext = {1'b0, o_lat_sum} + {1'b0, i_lat};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rx_pkt_cnt <= '0;
      o_err_cnt    <= '0;
      o_lat_min    <= '1;
      o_lat_max    <= '0;
      o_lat_sum    <= '0;
    end else if (i_clr) begin
      o_rx_pkt_cnt <= '0;
      o_err_cnt    <= '0;
      o_lat_min    <= '1;
      o_lat_max    <= '0;
      o_lat_sum    <= '0;
    end else if (i_upd) begin
      if (i_good) begin
        o_rx_pkt_cnt <= sat_inc32(o_rx_pkt_cnt);
        o_lat_sum    <= sum_ext[64] ? '1
                                    : sum_ext[63:0];
        if (i_lat < o_lat_min) o_lat_min <= i_lat;
        if (i_lat > o_lat_max) o_lat_max <= i_lat;
      end else begin
        o_err_cnt <= sat_inc32(o_err_cnt);
      end
    end
  end

endmodule

// File: rtl/server_rx_monitor.sv
// Rx monitor: parses test packets, reports latency and errors.
// Ports: AXIS slave bus, timestamp, stat clear, report + stats outputs.
module server_rx_monitor
  import server_rx_monitor_pkg::*;
#(
  parameter logic [47:0] P_MY_PORT_MAC = {MAC_HEAD, 16'h0001},
  parameter int          P_PKT_LEN     = 128
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         i_time_stamp,
  input  logic                i_clr_stat,
  server_rx_monitor_if.slave  rx_axis,
  output logic                o_pkt_valid,
  output logic [47:0]         o_src_mac,
  output logic [63:0]         o_latency,
  output logic [15:0]         o_pkt_len,
  output logic [2:0]          o_err_code,
  output logic [31:0]         o_rx_pkt_cnt,
  output logic [31:0]         o_err_cnt,
  output logic [63:0]         o_lat_min,
  output logic [63:0]         o_lat_max,
  output logic [63:0]         o_lat_sum
);

  localparam logic [15:0] LEN_W = 16'(P_PKT_LEN);

  rx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n, beat;
  logic        dest_bad, dest_bad_n;
  logic        etype_bad, etype_bad_n;
  logic [47:0] src, src_n;
  logic [63:0] tx_ts, tx_ts_n;
  logic        runt;
  logic        rpt_v;
  rx_rpt_t     rpt;
  logic        unused_tkeep;

  assign rx_axis.tready = 1'b1;
  assign unused_tkeep   = ^rx_axis.tkeep;

  // cnt is 0 in IDLE, so beat is the 1-based index of this beat
  assign beat = sat_inc16(cnt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dest_bad  <= 1'b0;
      etype_bad <= 1'b0;
      src       <= '0;
      tx_ts     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dest_bad  <= dest_bad_n;
      etype_bad <= etype_bad_n;
      src       <= src_n;
      tx_ts     <= tx_ts_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dest_bad_n  = dest_bad;
    etype_bad_n = etype_bad;
    src_n       = src;
    tx_ts_n     = tx_ts;
    runt        = 1'b0;
    rpt_v       = 1'b0;
    rpt         = '0;
    if (rx_axis.tvalid) begin
      cnt_n = rx_axis.tlast ? 16'd0 : beat;
      unique case (state)
        S_IDLE: begin
          dest_bad_n  = rx_axis.tdata[63:16]
                        != P_MY_PORT_MAC;
          etype_bad_n = 1'b0;
          src_n       = {rx_axis.tdata[15:0], 32'h0};
          runt        = 1'b1;
          if (!rx_axis.tlast) state_n = S_HDR1;
        end
        S_HDR1: begin
          src_n[31:0] = rx_axis.tdata[63:32];
          etype_bad_n = rx_axis.tdata[31:16]
                        != ETH_IPV4;
          runt        = 1'b1;
          state_n     = rx_axis.tlast ? S_IDLE
                                      : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (cnt == 16'd2) tx_ts_n = rx_axis.tdata;
          if (rx_axis.tlast)     state_n = S_IDLE;
          else if (beat > LEN_W) state_n = S_DRAIN;
        end
        S_DRAIN: begin
          if (rx_axis.tlast) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
      if (rx_axis.tlast) begin
        rpt_v   = 1'b1;
        rpt.src = src_n;
        rpt.len = beat;
        rpt.lat = runt ? 64'd0
                       : i_time_stamp - tx_ts_n;
        rpt.err = pick_err(runt, dest_bad_n,
                           etype_bad_n,
                           beat != LEN_W,
                           rx_axis.tuser);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pkt_valid <= 1'b0;
      o_src_mac   <= '0;
      o_latency   <= '0;
      o_pkt_len   <= '0;
      o_err_code  <= '0;
    end else begin
      o_pkt_valid <= rpt_v;
      if (rpt_v) begin
        o_src_mac  <= rpt.src;
        o_latency  <= rpt.lat;
        o_pkt_len  <= rpt.len;
        o_err_code <= rpt.err;
      end
    end
  end

  rx_lat_stats u_stats (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (i_clr_stat),
    .i_upd        (rpt_v),
    .i_good       (rpt.err == ERR_OK),
    .i_lat        (rpt.lat),
    .o_rx_pkt_cnt (o_rx_pkt_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_lat_min    (o_lat_min),
    .o_lat_max    (o_lat_max),
    .o_lat_sum    (o_lat_sum)
  );

endmodule
